ctrl_rr_dispatch: RTL
=====================

# ctrl_rr_dispatch

Round-robin event dispatcher that shares one event-handler input stream among PORT_COUNT producer streams of the same event type. It sits between the per-source barrier-queued controllers and the shared handler pipeline. It grants one producer per event and holds the grant until that event's tlast beat. It also bounds the number of events outstanding in the handler with an in-flight credit counter that is retired by handler completion pulses.

## Interface
- PORT_COUNT, 4: number of producer streams, 2..16.
- DATA_WIDTH, 512: tdata width per stream.
- KEEP_ENABLE, 1: 1 = tkeep carried; 0 = s_tkeep ignored and m_tkeep driven all-ones.
- MAX_INFLIGHT, 8: maximum events granted but not yet completed, 1..255.
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous, active-high.
- s_tdata  in  PORT_COUNT*DATA_WIDTH  producer data; port i occupies slice i.
- s_tkeep  in  PORT_COUNT*DATA_WIDTH/8  producer byte enables.
- s_tlast  in  PORT_COUNT  last beat of event.
- s_tvalid  in  PORT_COUNT  producer valid.
- s_tready  out  PORT_COUNT  producer ready.
- m_tdata  out  DATA_WIDTH  to handler.
- m_tkeep  out  DATA_WIDTH/8  to handler.
- m_tlast  out  1  to handler.
- m_tid  out  $clog2(PORT_COUNT)  index of the granted producer, stable for the whole event.
- m_tvalid  out  1  to handler.
- m_tready  in  1  from handler.
- done  in  1  one pulse per event retired by the handler.
- inflight  out  8  current outstanding-event count.
- err  out  1  sticky; set when done arrives while inflight = 0.

## Operation
- FSM states:
  - IDLE: no grant. m_tvalid = 0, all s_tready = 0.
  - BUSY: grant register g selects one port.
- IDLE -> BUSY:
  - Requires any s_tvalid and inflight < MAX_INFLIGHT (inflight evaluated including a same-cycle done).
  - Winner is the first asserted s_tvalid searching ptr+1, ptr+2, … modulo PORT_COUNT.
  - g <= winner; inflight increments that cycle.
- BUSY forwarding is combinational from port g:
  - m_tdata, m_tkeep, m_tlast, m_tvalid = port g signals.
  - s_tready[g] = m_tready; all other s_tready = 0.
- BUSY -> IDLE on an accepted beat with m_tlast = 1 (m_tvalid & m_tready & m_tlast). At the same time ptr <= g.
- Grant persistence: the grant is never revoked mid-event, including while s_tvalid[g] drops between beats.
- inflight arithmetic: next = inflight + grant_evt − (done & inflight != 0).
  - A grant and a done in the same cycle leave the count unchanged.
  - done at inflight = 0 is ignored and sets err.
  - The count never exceeds MAX_INFLIGHT.
- m_tid = g throughout BUSY, 0 in IDLE.
- KEEP_ENABLE = 0: m_tkeep = all ones.

## Timing
- Reset values:
  - State IDLE, ptr = PORT_COUNT−1 (port 0 wins first), g = 0.
  - inflight = 0, err = 0.
  - m_tvalid = 0, s_tready = 0, m_tid = 0.
- Arbitration latency: one bubble cycle. A request seen in IDLE at cycle t is granted at the edge ending t, and its first beat can transfer in cycle t+1.
- Throughput: one beat per cycle while m_tready = 1. Back-to-back events cost exactly one idle cycle between the tlast beat and the next event's first beat.
- A single-beat event (tlast on the first beat) occupies one BUSY cycle.
- Credit-full: IDLE holds with m_tvalid = 0 until done lowers inflight; the grant happens in the same cycle as that done.
- rst asserted mid-event: FSM returns to IDLE at the next edge and the partial event is abandoned. The handler must also be reset.
- Fairness: with all ports continuously valid, grants cycle 0,1,…,PORT_COUNT−1,0. No port waits more than PORT_COUNT−1 events.

## Test plan
- Reset, then s_tvalid = 4'b1111 with single-beat events and done tied high one cycle after each grant -> m_tid sequence 0,1,2,3,0; inflight ≤ 1; one idle cycle between beats.
- Port 2 sends a 3-beat event; port 0 raises valid mid-event; m_tready toggles 1,0,1,1 -> all three port-2 beats pass in order with m_tid = 2; port 0 is granted only after the tlast handshake; s_tready[0] stays 0 until then.
- MAX_INFLIGHT = 2, done held low, all ports valid -> exactly two events granted, then IDLE stall. One done pulse -> third event granted in the same cycle as the pulse; inflight stays at 2.
- done pulsed at inflight = 0 -> inflight stays 0, err rises and stays 1 until rst.
- KEEP_ENABLE = 0, port 1 tkeep = 0 -> m_tkeep = all ones, data 0xA5… passed unchanged.
- rst asserted on beat 2 of a 4-beat event -> next cycle m_tvalid = 0, inflight = 0. A new port-0 request afterwards is granted first.

Source files
------------

// File: rtl/ctrl_rr_dispatch.sv
// ctrl_rr_dispatch: round-robin event dispatcher sharing one handler stream among PORT_COUNT producers
// Ports:
//   clk, rst                  sole clock, synchronous active-high reset
//   s_tdata/s_tkeep/s_tlast   producer beats, port i in slice i
//   s_tvalid/s_tready         producer handshake, ready only toward the granted port
//   m_tdata/m_tkeep/m_tlast   beats forwarded from the granted port
//   m_tid                     granted port index, 0 while idle
//   m_tvalid/m_tready         handler handshake
//   done                      one pulse per event retired by the handler
//   inflight                  events granted but not yet retired
//   err                       sticky, done seen with nothing in flight
module ctrl_rr_dispatch #(
    parameter int PORT_COUNT   = 4,
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_ENABLE  = 1,
    parameter int MAX_INFLIGHT = 8,
    localparam int IW = $clog2(PORT_COUNT),
    localparam int KW = DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_tdata,
    input  logic [PORT_COUNT*KW-1:0]   s_tkeep,
    input  logic [PORT_COUNT-1:0]      s_tlast,
    input  logic [PORT_COUNT-1:0]      s_tvalid,
    output logic [PORT_COUNT-1:0]      s_tready,
    output logic [DATA_WIDTH-1:0]      m_tdata,
    output logic [KW-1:0]              m_tkeep,
    output logic                       m_tlast,
    output logic [IW-1:0]              m_tid,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    input  logic                       done,
    output logic [7:0]                 inflight,
    output logic                       err
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;
    logic [IW-1:0] g, ptr, win;
    logic found, done_eff, grant;
    // First valid port after the last served one, wrapping around.
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int i = 1; i <= PORT_COUNT; i++) begin
            if (!found && s_tvalid[IW'((int'(ptr) + i) % PORT_COUNT)]) begin
                win = IW'((int'(ptr) + i) % PORT_COUNT);
                found = 1'b1;
            end
        end
    end
    assign done_eff = done && inflight != 8'd0;
    // A same-cycle retirement frees a credit for this grant.
    assign grant    = state == IDLE && found && (inflight - 8'(done_eff)) < 8'(MAX_INFLIGHT);
    assign m_tvalid = state == BUSY && s_tvalid[g];
    assign m_tlast  = state == BUSY && s_tlast[g];
    assign m_tdata  = s_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign m_tkeep  = KEEP_ENABLE != 0 ? s_tkeep[g*KW +: KW] : '1;
    assign m_tid    = state == BUSY ? g : '0;
    assign s_tready = state == BUSY && m_tready ? PORT_COUNT'(1) << g : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            g        <= '0;
            ptr      <= IW'(PORT_COUNT - 1);
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            inflight <= inflight + 8'(grant) - 8'(done_eff);
            err      <= err | (done && inflight == 8'd0);
            if (grant) begin
                state <= BUSY;
                g     <= win;
            end else if (m_tvalid && m_tready && m_tlast) begin
                state <= IDLE;
                ptr   <= g;
            end
        end
    end
endmodule
